mole_game_engine: RTL and testbench

N-channel reaction-game engine that drives target LEDs with independently programmable on/off periods, detects button hits on lit targets, counts misses, and delivers score increments to the processor register-file write port over a valid/ready handshake. It sits between the board I/O (LEDs, push-buttons) and the CPU/regfile score-injection mux, and replaces the fixed four-channel game logic with a width- and channel-parametrised block that has synchronised inputs, miss tracking and a formal game FSM.

---
 rtl/mole_pkg.sv | 26 ++
 rtl/mole_game_engine_channel.sv | 80 ++++++++
 rtl/mole_game_engine.sv | 163 ++++++++++++++++
 tb/tb_mole_game_engine.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared types and helpers for the mole reaction-game engine.
package mole_pkg;

  typedef enum logic {
    GAME_PLAY = 1'b0,
    GAME_END  = 1'b1
  } game_state_e;

  localparam logic ST_PLAY = GAME_PLAY;
  localparam logic ST_END  = GAME_END;

  localparam int MISS_W = 16;

  // Adds a + b and clamps the result to max_val; operands are zero-extended.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) begin
      return max_val;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/mole_game_engine_channel.sv
// One target channel: button synchroniser, press detector and LIT/DARK phase timer.
module mole_channel
  import mole_pkg::*;
#(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_n,
  input  logic             run,
  input  logic             clear,
  input  logic [CNT_W-1:0] on_period,
  input  logic [CNT_W-1:0] off_period,
  output logic             led,
  output logic             hit,
  output logic             miss
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic             prev_q;
  logic             press;
  logic             lit_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] on_last;
  logic [CNT_W-1:0] off_last;
  logic             lit_done;
  logic             dark_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign press = prev_q & ~sync2_q;

  // A zero period behaves as one cycle; >= keeps a live period shrink from running cnt past the limit.
  assign on_last   = (on_period == '0) ? '0 : on_period - CNT_ONE;
  assign off_last  = (off_period == '0) ? '0 : off_period - CNT_ONE;
  assign lit_done  = (cnt_q >= on_last);
  assign dark_done = (cnt_q >= off_last);

  // A press on the expiry cycle wins: it is a hit, not a miss.
  assign hit  = run & lit_q & press;
  assign miss = run & lit_q & ~press & lit_done;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lit_q <= 1'b1;
      cnt_q <= '0;
    end else if (!run) begin
      lit_q <= 1'b0;
      cnt_q <= '0;
    end else if (lit_q) begin
      if (hit || miss) begin
        lit_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end else if (dark_done) begin
      lit_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign led = lit_q & run;

endmodule

// File: rtl/mole_game_engine.sv
// N-channel reaction-game engine: target timing, hit scoring, miss counting and PLAY/END control.
module mole_game_engine
  import mole_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 26,
  parameter int INC_W       = 8,
  parameter int SCORE_W     = 32,
  parameter int WIN_SCORE   = 12,
  parameter int LOCKOUT_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       btn_n,
  input  logic                  restart_n,
  input  logic [N_CH*CNT_W-1:0] on_period,
  input  logic [N_CH*CNT_W-1:0] off_period,
  input  logic [SCORE_W-1:0]    score_total,
  input  logic                  score_inc_ready,
  output logic                  score_inc_valid,
  output logic [INC_W-1:0]      score_inc,
  output logic [N_CH-1:0]       led,
  output logic                  end_led,
  output logic [15:0]           miss_count,
  output logic                  game_clear,
  output logic                  state
);

  localparam int HIT_W  = $clog2(N_CH + 1);
  localparam int LOCK_W = $clog2(LOCKOUT_CYC + 2);

  localparam logic [31:0]        ACC_MAX  = (INC_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << INC_W) - 32'd1);
  localparam logic [31:0]        MISS_MAX = (32'd1 << MISS_W) - 32'd1;
  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
  localparam logic [LOCK_W-1:0]  LOCK_MAX = LOCK_W'(LOCKOUT_CYC);

  logic              state_q;
  logic [LOCK_W-1:0] lockout_q;
  logic [INC_W-1:0]  acc_q;
  logic [INC_W-1:0]  acc_base;
  logic [INC_W-1:0]  acc_next;
  logic [MISS_W-1:0] miss_q;
  logic [MISS_W-1:0] miss_next;
  logic              game_clear_q;

  logic              rst_sync1_q;
  logic              rst_sync2_q;
  logic              rst_prev_q;
  logic              restart_press;
  logic              restart_go;
  logic              win;
  logic              run;

  logic [N_CH-1:0]   hit_vec;
  logic [N_CH-1:0]   miss_vec;
  logic [HIT_W-1:0]  hit_cnt;
  logic [HIT_W-1:0]  miss_cnt;

  assign run = (state_q == ST_PLAY);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    mole_channel #(
      .CNT_W(CNT_W)
    ) u_channel (
      .clk       (clk),
      .reset     (reset),
      .btn_n     (btn_n[i]),
      .run       (run),
      .clear     (restart_go),
      .on_period (on_period[i*CNT_W +: CNT_W]),
      .off_period(off_period[i*CNT_W +: CNT_W]),
      .led       (led[i]),
      .hit       (hit_vec[i]),
      .miss      (miss_vec[i])
    );
  end

  always_comb begin
    hit_cnt  = '0;
    miss_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      hit_cnt  = hit_cnt + HIT_W'(hit_vec[i]);
      miss_cnt = miss_cnt + HIT_W'(miss_vec[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_sync1_q <= 1'b1;
      rst_sync2_q <= 1'b1;
      rst_prev_q  <= 1'b1;
    end else begin
      rst_sync1_q <= restart_n;
      rst_sync2_q <= rst_sync1_q;
      rst_prev_q  <= rst_sync2_q;
    end
  end

  assign restart_press = rst_prev_q & ~rst_sync2_q;
  assign restart_go    = (state_q == ST_END) && restart_press && (lockout_q >= LOCK_MAX);
  assign win           = (state_q == ST_PLAY) && (score_total >= WIN_VAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_PLAY;
    end else begin
      case (state_q)
        ST_PLAY: if (win)        state_q <= ST_END;
        ST_END:  if (restart_go) state_q <= ST_PLAY;
        default:                 state_q <= ST_PLAY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || win) begin
      lockout_q <= '0;
    end else if ((state_q == ST_END) && (lockout_q < LOCK_MAX)) begin
      lockout_q <= lockout_q + LOCK_W'(1);
    end
  end

  // Score handshake: an increment transfers on a rising edge where score_inc_valid and
  // score_inc_ready are both high; the value shown in that cycle is consumed, and hits
  // arriving in the same cycle seed the next pending value. Valid never waits for ready.
  always_comb begin
    acc_base  = (score_inc_valid && score_inc_ready) ? '0 : acc_q;
    acc_next  = INC_W'(sat_add(32'(acc_base), 32'(hit_cnt), ACC_MAX));
    miss_next = MISS_W'(sat_add(32'(miss_q), 32'(miss_cnt), MISS_MAX));
  end

  always_ff @(posedge clk) begin
    if (reset || win || !run) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || restart_go) begin
      miss_q <= '0;
    end else begin
      miss_q <= miss_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      game_clear_q <= 1'b0;
    end else begin
      game_clear_q <= restart_go;
    end
  end

  assign score_inc_valid = (acc_q != '0);
  assign score_inc       = acc_q;
  assign end_led         = (state_q == ST_END);
  assign miss_count      = miss_q;
  assign game_clear      = game_clear_q;
  assign state           = state_q;

endmodule

// File: tb/tb_mole_game_engine.sv
// Directed-vector bench for mole_game_engine with a score-delivery scoreboard.
module tb_mole_game_engine;

  localparam int N_CH  = 4;
  localparam int CNT_W = 26;
  localparam int INC_W = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N_CH-1:0]       btn_n;
  logic [N_CH-1:0]       btn2_n;
  logic                  restart_n;
  logic [N_CH*CNT_W-1:0] on_period;
  logic [N_CH*CNT_W-1:0] off_period;
  logic [31:0]           score_total;
  logic                  score_inc_ready;
  logic                  score_inc_valid;
  logic [INC_W-1:0]      score_inc;
  logic [N_CH-1:0]       led;
  logic                  end_led;
  logic [15:0]           miss_count;
  logic                  game_clear;
  logic                  state;

  logic                  valid2;
  logic [1:0]            score_inc2;
  logic [N_CH-1:0]       led2;
  logic                  end_led2;
  logic [15:0]           miss_count2;
  logic                  game_clear2;
  logic                  state2;

  logic [INC_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mole_game_engine dut (
    .clk            (clk),
    .reset          (reset),
    .btn_n          (btn_n),
    .restart_n      (restart_n),
    .on_period      (on_period),
    .off_period     (off_period),
    .score_total    (score_total),
    .score_inc_ready(score_inc_ready),
    .score_inc_valid(score_inc_valid),
    .score_inc      (score_inc),
    .led            (led),
    .end_led        (end_led),
    .miss_count     (miss_count),
    .game_clear     (game_clear),
    .state          (state)
  );

  // Narrow accumulator instance for the saturation case; never ready, never wins.
  mole_game_engine #(.INC_W(2)) dut2 (
    .clk            (clk),
    .reset          (reset),
    .btn_n          (btn2_n),
    .restart_n      (1'b1),
    .on_period      (on_period),
    .off_period     (off_period),
    .score_total    (32'd0),
    .score_inc_ready(1'b0),
    .score_inc_valid(valid2),
    .score_inc      (score_inc2),
    .led            (led2),
    .end_led        (end_led2),
    .miss_count     (miss_count2),
    .game_clear     (game_clear2),
    .state          (state2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: every accepted transfer must match the next expected increment.
  initial begin
    logic [INC_W-1:0] exp_v;
    forever begin
      @(negedge clk);
      #1;
      if (reset === 1'b0 && score_inc_valid && score_inc_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL deliver_unexpected: got %0d, required no transfer", score_inc);
        end else begin
          exp_v = exp_q.pop_front();
          if (score_inc !== exp_v) begin
            n_err++;
            $display("FAIL deliver: got %0d, required %0d", score_inc, exp_v);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    reset           = 1'b1;
    btn_n           = '1;
    btn2_n          = '1;
    restart_n       = 1'b1;
    score_total     = 32'd0;
    score_inc_ready = 1'b0;
    on_period       = {N_CH{26'd5}};
    off_period      = {N_CH{26'd3}};
    cyc(3);

    check("rst_state", state, 0);
    check("rst_led", led, 4'hF);
    check("rst_end_led", end_led, 0);
    check("rst_valid", score_inc_valid, 0);
    check("rst_miss", miss_count, 0);
    check("rst_clear", game_clear, 0);

    // Free-running pattern: 5 lit, 3 dark; all four channels miss together every 8 cycles.
    reset = 1'b0;
    for (int j = 0; j < 16; j++) begin
      check("led0_pattern", led[0], ((j % 8) < 5) ? 1 : 0);
      check("miss_pattern", miss_count, 4 * ((j + 3) / 8));
      if (j == 3) check("sat_inc_1", score_inc2, 1);
      if (j == 4) check("sat_inc_4hits", score_inc2, 3);
      if (j == 8) begin
        check("sat_inc_5hits", score_inc2, 3);
        check("sat_valid", valid2, 1);
      end
      if (j == 0) btn2_n = 4'b1110;
      if (j == 1) btn2_n = 4'b0000;
      if (j == 3) btn2_n = 4'b1111;
      if (j == 5) btn2_n = 4'b1110;
      if (j == 6) btn2_n = 4'b1111;
      cyc(1);
    end

    // Dual hit on ch0 and ch2, ready low.
    btn_n = 4'b1010;
    cyc(2);
    check("pre_hit_led", led, 4'hF);
    check("pre_hit_valid", score_inc_valid, 0);
    cyc(1);
    check("dual_hit_led", led, 4'b1010);
    check("dual_hit_inc", score_inc, 2);
    check("dual_hit_valid", score_inc_valid, 1);
    btn_n = 4'b1111;
    cyc(2);
    check("miss_after_hit", miss_count, 10);

    // Third hit brings acc to 3; a fourth lands in the same cycle as the transfer.
    btn_n = 4'b1110;
    cyc(1);
    btn_n = 4'b1010;
    cyc(2);
    check("acc_three", score_inc, 3);
    exp_q.push_back(8'd3);
    exp_q.push_back(8'd1);
    score_inc_ready = 1'b1;
    cyc(1);
    check("concurrent_inc", score_inc, 1);
    check("concurrent_valid", score_inc_valid, 1);
    cyc(1);
    check("drained_valid", score_inc_valid, 0);
    score_inc_ready = 1'b0;
    btn_n = '1;

    // Win threshold boundary and END entry.
    score_total = 32'd11;
    cyc(1);
    check("below_win_state", state, 0);
    score_total = 32'd12;
    cyc(1);
    check("end_state", state, 1);
    check("end_led_off", led, 4'h0);
    check("end_led_on", end_led, 1);
    check("end_valid", score_inc_valid, 0);
    score_total = 32'd0;
    cyc(1);
    check("end_hold", state, 1);

    // Restart pressed around lockout 460 must be ignored.
    cyc(460);
    restart_n = 1'b0;
    cyc(10);
    restart_n = 1'b1;
    cyc(10);
    check("early_restart_state", state, 1);
    check("early_restart_clear", game_clear, 0);

    // Restart after the lockout has expired.
    cyc(520);
    restart_n = 1'b0;
    k = 0;
    while (k < 10 && game_clear !== 1'b1) begin
      cyc(1);
      k++;
    end
    check("restart_latency", k, 3);
    check("restart_state", state, 0);
    check("restart_led", led, 4'hF);
    check("restart_miss", miss_count, 0);
    check("restart_end_led", end_led, 0);
    restart_n = 1'b1;

    // Zero on-period: one lit cycle, then the usual 3 dark.
    on_period = '0;
    cyc(1);
    check("clear_pulse_end", game_clear, 0);
    check("zero_on_led1", led, 4'h0);
    check("zero_on_miss", miss_count, 4);
    cyc(2);
    check("zero_on_led3", led, 4'h0);
    cyc(1);
    check("zero_on_relit", led, 4'hF);
    on_period = {N_CH{26'd5}};
    cyc(1);
    check("restored_led", led, 4'hF);
    check("restored_miss", miss_count, 4);

    // Held button: one press only.
    btn_n = 4'b1101;
    cyc(100);
    btn_n = 4'b1111;
    cyc(5);
    check("held_one_hit", score_inc, 1);
    exp_q.push_back(8'd1);
    score_inc_ready = 1'b1;
    cyc(1);
    check("held_drained", score_inc_valid, 0);
    score_inc_ready = 1'b0;

    // Mid-game reset: reset values, no clear pulse.
    reset = 1'b1;
    cyc(2);
    check("midrst_clear", game_clear, 0);
    check("midrst_led", led, 4'hF);
    check("midrst_miss", miss_count, 0);
    reset = 1'b0;
    cyc(1);
    check("midrst_clear_after", game_clear, 0);
    check("midrst_state", state, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
